// File: rtl/ray_pixel_dispatcher_pkg.sv
// Shared state type, default sizing and width helpers for the ray pixel dispatcher.
package ray_pkg;

    localparam int DEF_H_RES   = 320;
    localparam int DEF_V_RES   = 240;
    localparam int DEF_COLOR_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } disp_state_t;

    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int addr_w(input int h, input int v);
        return (h * v > 1) ? $clog2(h * v) : 1;
    endfunction

endpackage

// File: rtl/ray_pixel_dispatcher_raster_counter.sv
// Raster-order x/y walker with a registered linear framebuffer address.
module raster_counter
    import ray_pkg::*;
#(
    parameter int H_RES  = DEF_H_RES,
    parameter int V_RES  = DEF_V_RES,
    parameter int X_W    = coord_w(H_RES),
    parameter int Y_W    = coord_w(V_RES),
    parameter int ADDR_W = addr_w(H_RES, V_RES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    output logic [X_W-1:0]    x,
    output logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    localparam logic [X_W-1:0] X_MAX = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(V_RES - 1);

    logic x_last;

    assign x_last     = (x == X_MAX);
    assign last_pixel = x_last && (y == Y_MAX);

    // Raster order means y*H_RES+x just steps by one, so no multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clear) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (advance && !last_pixel) begin
            addr <= addr + 1'b1;
            if (x_last) begin
                x <= '0;
                y <= y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ray_pixel_dispatcher.sv
// Frame initiator: walks pixels in raster order, launches the core, writes colours.
// Define RAY_DISPATCH_PERF_EN to add the perf_cycles frame-length counter.
module ray_pixel_dispatcher
    import ray_pkg::*;
#(
    parameter int H_RES   = DEF_H_RES,
    parameter int V_RES   = DEF_V_RES,
    parameter int COLOR_W = DEF_COLOR_W,
    parameter int X_W     = coord_w(H_RES),
    parameter int Y_W     = coord_w(V_RES),
    parameter int ADDR_W  = addr_w(H_RES, V_RES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    output logic               frame_busy,
    output logic               frame_done,
    output logic               core_start,
    output logic [X_W-1:0]     core_x,
    output logic [Y_W-1:0]     core_y,
    input  logic               core_busy,
    input  logic               core_pixel_valid,
    input  logic [COLOR_W-1:0] core_color,
    output logic               fb_we,
    output logic [ADDR_W-1:0]  fb_addr,
    output logic [COLOR_W-1:0] fb_data,
    input  logic               fb_ready
`ifdef RAY_DISPATCH_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    disp_state_t state, state_nx;
    logic        clear, advance, capture, last_pixel;

    raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W),
        .ADDR_W(ADDR_W)
    ) u_raster (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .advance   (advance),
        .x         (core_x),
        .y         (core_y),
        .addr      (fb_addr),
        .last_pixel(last_pixel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        core_start = 1'b0;
        fb_we      = 1'b0;
        clear      = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        unique case (state)
            IDLE: begin
                if (frame_start) begin
                    clear    = 1'b1;
                    state_nx = ISSUE;
                end
            end
            ISSUE: begin
                frame_busy = 1'b1;
                if (!core_busy) begin
                    core_start = 1'b1;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                frame_busy = 1'b1;
                if (core_pixel_valid) begin
                    capture  = 1'b1;
                    state_nx = WRITE;
                end
            end
            WRITE: begin
                frame_busy = 1'b1;
                fb_we      = 1'b1;
                if (fb_ready) begin
                    advance  = 1'b1;
                    state_nx = last_pixel ? DONE : ISSUE;
                end
            end
            DONE: begin
                frame_busy = 1'b1;
                frame_done = 1'b1;
                state_nx   = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          fb_data <= '0;
        else if (capture) fb_data <= core_color;
    end

`ifdef RAY_DISPATCH_PERF_EN
    // Counts the accept cycle through the DONE cycle; frozen while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles <= '0;
        end else if (state == IDLE) begin
            if (frame_start) perf_cycles <= 32'd1;
        end else if (perf_cycles != 32'hFFFF_FFFF) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/ray_pixel_dispatcher.md
Name: ray_pixel_dispatcher

Overview:
- Frame-level initiator for the ray-trace core.
- Walks the screen in raster order and, for each pixel, pulses the core's start with (x, y).
- Waits for the core to return a pixel colour, then writes that colour to the framebuffer through a ready/valid-style write port.
- Sits between the frame controller (frame_start/frame_done) and the tracing core; it is the requesting end of the core's start/busy/done protocol.

Parameters:
- H_RES, 320, horizontal resolution in pixels
- V_RES, 240, vertical resolution in lines
- COLOR_W, 16, colour word width returned by core and written to framebuffer
- X_W, $clog2(H_RES), x coordinate width (derived)
- Y_W, $clog2(V_RES), y coordinate width (derived)
- ADDR_W, $clog2(H_RES*V_RES), framebuffer address width (derived)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  request to render one frame; sampled only in IDLE
- frame_busy  out  1  high from accepted frame_start until frame_done
- frame_done  out  1  one-cycle pulse after the last pixel is written
- core_start  out  1  one-cycle pulse launching trace of core_x/core_y
- core_x  out  X_W  pixel x; stable from core_start until core_pixel_valid
- core_y  out  Y_W  pixel y; same stability rule as core_x
- core_busy  in  1  core busy; core_start is never issued while high
- core_pixel_valid  in  1  one-cycle pulse, core_color valid
- core_color  in  COLOR_W  traced pixel colour
- fb_we  out  1  framebuffer write request, held until accepted
- fb_addr  out  ADDR_W  y*H_RES + x
- fb_data  out  COLOR_W  captured colour
- fb_ready  in  1  framebuffer accepts the write when fb_we && fb_ready

Behaviour:
- Reset (async, immediate):
  - state=IDLE, x=0, y=0.
  - All outputs are 0 (frame_busy, frame_done, core_start, fb_we, core_x, core_y, fb_addr, fb_data).
  - Reset mid-frame abandons the frame with no frame_done; any later core_pixel_valid is ignored.
- IDLE:
  - On frame_start=1: go to ISSUE, x=y=0, frame_busy=1 from the next cycle.
  - frame_start while not in IDLE is ignored (no queueing).
- ISSUE:
  - If core_busy=0: core_start=1 for exactly this cycle, go to WAIT.
  - Otherwise stay in ISSUE with core_start=0.
- WAIT:
  - On core_pixel_valid=1: capture core_color into fb_data, drive fb_addr, go to WRITE.
  - core_pixel_valid outside WAIT is ignored.
  - No timeout.
- WRITE:
  - fb_we=1 with fb_addr and fb_data held stable.
  - On fb_we && fb_ready:
    - fb_we drops next cycle.
    - If x==H_RES-1 && y==V_RES-1: go to DONE.
    - Else if x==H_RES-1: x=0, y=y+1, go to ISSUE.
    - Else: x=x+1, go to ISSUE.
- DONE:
  - frame_done=1 for one cycle, frame_busy=0 from the next cycle, go to IDLE.
  - A frame_start asserted in the DONE cycle is ignored; it is accepted in IDLE on the following cycle.
- Minimum per-pixel latency, with core_busy=0 and fb_ready=1:
  - 1 cycle in ISSUE, plus the core latency, plus 1 cycle in WRITE.
- Arithmetic:
  - fb_addr is computed from registered x,y and truncated/zero-extended to ADDR_W.
  - No wrap beyond the last pixel; the counters stop at (H_RES-1, V_RES-1).

Optional Feature:
- Macro: RAY_DISPATCH_PERF_EN.
- When defined:
  - Adds output perf_cycles[31:0]: cycle count from accepted frame_start to frame_done inclusive.
  - The count saturates at 32'hFFFF_FFFF, holds its value in IDLE, clears on the next accepted frame_start, and resets to 0.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ray_pkg holds:
  - the dispatcher state enum (IDLE, ISSUE, WAIT, WRITE, DONE);
  - the default resolution and colour-width localparams;
  - the coordinate/address width functions.
- One sub-module, raster_counter:
  - x/y counter with clear, advance, last_pixel flag, and registered linear address output.

Test Plan:
- H_RES=4, V_RES=2; core returns valid 3 cycles after start with colour=16'h1000+addr; fb_ready=1.
  - Expect 8 fb writes at addr 0..7 with data 16'h1000..16'h1007, then one frame_done pulse.
- Hold core_busy=1 for 5 cycles at pixel 2.
  - Expect no core_start during those cycles, core_x/core_y held at (2,0), then a single start.
- fb_ready low for 4 cycles during the write of addr 5.
  - Expect fb_we held with addr=5 and data stable, x/y not advancing; exactly one write accepted.
- frame_start pulsed mid-frame, and a spurious core_pixel_valid injected in ISSUE.
  - Expect both ignored: exactly 8 writes, one frame_done.
- Assert rst in WAIT at pixel 3.
  - Expect all outputs 0 immediately, no frame_done; the next frame restarts at (0,0).
- With RAY_DISPATCH_PERF_EN, core latency 3, fb_ready=1.
  - Expect perf_cycles equal to the cycle count measured by the bench and stable after frame_done.
